// File: rtl/uart_cmd_rx.sv
// 8N1 serial command receiver: deserializes bytes from RX, holds them behind a
// rdy/clr_rdy handshake, flags framing/overrun errors and decodes go/stop bytes.
module uart_cmd_rx #(
  parameter int         BAUD_DIV = 2604,
  parameter logic [7:0] CMD_GO   = 8'h67,
  parameter logic [7:0] CMD_STOP = 8'h73
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr,
  output logic       cmd_go,
  output logic       cmd_stop
);

  localparam int               CNT_W    = $clog2(BAUD_DIV + 1);
  localparam logic [CNT_W-1:0] FULL_RLD = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_RLD = CNT_W'(BAUD_DIV / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_meta_q, rx_s_q;
  logic             rdy_q, rdy_d;
  logic             pend_q, pend_d;
  logic             ovr_q, ovr_d;
  logic             frm_q, frm_d;
  logic             go_q, go_d;
  logic             stop_q, stop_d;
  logic             expire, good, start_ok;

  assign expire = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = expire ? cnt_q : cnt_q - CNT_W'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    good      = 1'b0;
    start_ok  = 1'b0;
    frm_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = HALF_RLD;
        end
      end
      START: begin
        if (expire) begin
          if (!rx_s_q) begin
            state_d  = DATA;
            cnt_d    = FULL_RLD;
            idx_d    = 3'd0;
            start_ok = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (expire) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = FULL_RLD;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (expire) begin
          if (rx_s_q) begin
            good      = 1'b1;
            rx_data_d = shift_q;
            state_d   = IDLE;
          end else begin
            frm_d   = 1'b1;
            state_d = BRK;
          end
        end
      end
      BRK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // pend tracks "byte not yet acknowledged"; unlike rdy it survives the
    // clear at start-bit validation, so an unread byte can still be flagged.
    rdy_d = rdy_q;
    if (clr_rdy || start_ok) rdy_d = 1'b0;
    if (good) rdy_d = 1'b1;
    pend_d = pend_q;
    if (clr_rdy) pend_d = 1'b0;
    if (good) pend_d = 1'b1;
    ovr_d = ovr_q;
    if (clr_rdy) ovr_d = 1'b0;
    if (good && pend_q) ovr_d = 1'b1;
    go_d   = good && (shift_q == CMD_GO);
    stop_d = good && (shift_q == CMD_STOP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      rx_data_q <= 8'h00;
      rdy_q     <= 1'b0;
      pend_q    <= 1'b0;
      ovr_q     <= 1'b0;
      frm_q     <= 1'b0;
      go_q      <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rx_data_q <= rx_data_d;
      rdy_q     <= rdy_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      frm_q     <= frm_d;
      go_q      <= go_d;
      stop_q    <= stop_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign rx_data  = rx_data_q;
  assign rdy      = rdy_q;
  assign frm_err  = frm_q;
  assign ovr      = ovr_q;
  assign cmd_go   = go_q;
  assign cmd_stop = stop_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: drives 8N1 frames onto RX and checks the
// handshake, error flags and command pulses with immediate assertions.
module tb_uart_cmd_rx;

  localparam int B = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy, frm_err, ovr, cmd_go, cmd_stop;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t_start = 0;
  int t_rdy = 0;
  int go_cnt = 0;
  int stp_cnt = 0;
  int frm_cnt = 0;
  int bad_pulse = 0;
  logic rdy_prev = 1'b0;

  always #5 clk = ~clk;

  uart_cmd_rx #(.BAUD_DIV(B)) dut (
    .clk     (clk),
    .rst     (rst),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err),
    .ovr     (ovr),
    .cmd_go  (cmd_go),
    .cmd_stop(cmd_stop)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: command pulses must land on the cycle rdy rises.
  always @(negedge clk) begin
    if (cmd_go) begin
      go_cnt <= go_cnt + 1;
      if (!(rdy && !rdy_prev)) bad_pulse <= bad_pulse + 1;
    end
    if (cmd_stop) begin
      stp_cnt <= stp_cnt + 1;
      if (!(rdy && !rdy_prev)) bad_pulse <= bad_pulse + 1;
    end
    if (frm_err) frm_cnt <= frm_cnt + 1;
    if (rdy && !rdy_prev) t_rdy <= cyc;
    rdy_prev <= rdy;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input int bt, input logic stopv);
    RX = 1'b0;
    t_start = cyc;
    tick(bt);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(bt);
    end
    RX = stopv;
    tick(bt);
  endtask

  task automatic clr();
    clr_rdy = 1'b1;
    tick(1);
    clr_rdy = 1'b0;
    tick(1);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    RX = 1'b1;
    clr_rdy = 1'b0;
    tick(3);
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_rdy", 32'(rdy), 32'h0);
    chk("rst_frm_err", 32'(frm_err), 32'h0);
    chk("rst_ovr", 32'(ovr), 32'h0);
    chk("rst_cmd_go", 32'(cmd_go), 32'h0);
    chk("rst_cmd_stop", 32'(cmd_stop), 32'h0);
    rst = 1'b0;
    tick(4);

    // Basic reception and latency: 9.5*64+3 = 611 clocks from the start edge.
    send(8'hA5, B, 1'b1);
    lat = t_rdy - t_start;
    chk("a5_data", 32'(rx_data), 32'hA5);
    chk("a5_rdy", 32'(rdy), 32'h1);
    chk("a5_ovr", 32'(ovr), 32'h0);
    chk("a5_frm", 32'(frm_cnt), 32'h0);
    chk("a5_latency_in_610_612", 32'(lat >= 610 && lat <= 612), 32'h1);
    chk("a5_no_cmd", 32'(go_cnt + stp_cnt), 32'h0);

    clr();
    chk("clr_rdy", 32'(rdy), 32'h0);
    send(8'h67, B, 1'b1);
    chk("go_data", 32'(rx_data), 32'h67);
    chk("go_cnt", 32'(go_cnt), 32'h1);
    chk("go_stp_cnt", 32'(stp_cnt), 32'h0);
    clr();
    send(8'h73, B, 1'b1);
    chk("stop_data", 32'(rx_data), 32'h73);
    chk("stop_go_cnt", 32'(go_cnt), 32'h1);
    chk("stop_cnt", 32'(stp_cnt), 32'h1);
    chk("pulse_align", 32'(bad_pulse), 32'h0);
    chk("stop_rdy", 32'(rdy), 32'h1);

    // False start shorter than half a bit must leave everything alone.
    RX = 1'b0;
    tick(24);
    RX = 1'b1;
    tick(2 * B);
    chk("fs_rdy", 32'(rdy), 32'h1);
    chk("fs_data", 32'(rx_data), 32'h73);
    chk("fs_frm", 32'(frm_cnt), 32'h0);

    clr();
    send(8'h12, B, 1'b1);
    send(8'h34, B, 1'b1);
    chk("ovr_data", 32'(rx_data), 32'h34);
    chk("ovr_set", 32'(ovr), 32'h1);
    chk("ovr_rdy", 32'(rdy), 32'h1);
    clr();
    chk("ovr_clr_rdy", 32'(rdy), 32'h0);
    chk("ovr_clr_ovr", 32'(ovr), 32'h0);

    // Framing error followed by a held-low line, then a good frame.
    send(8'h55, B, 1'b0);
    RX = 1'b0;
    tick(3 * B);
    RX = 1'b1;
    tick(B);
    chk("frm_cnt", 32'(frm_cnt), 32'h1);
    chk("frm_rdy", 32'(rdy), 32'h0);
    chk("frm_data", 32'(rx_data), 32'h34);
    send(8'h3C, B, 1'b1);
    chk("post_frm_data", 32'(rx_data), 32'h3C);
    chk("post_frm_rdy", 32'(rdy), 32'h1);
    chk("post_frm_cnt", 32'(frm_cnt), 32'h1);
    chk("post_frm_cmds", 32'(go_cnt + stp_cnt), 32'h2);

    // Sender baud error of about +/-1.6 %.
    clr();
    send(8'h96, B - 1, 1'b1);
    chk("fast_data", 32'(rx_data), 32'h96);
    chk("fast_rdy", 32'(rdy), 32'h1);
    clr();
    send(8'h69, B + 1, 1'b1);
    chk("slow_data", 32'(rx_data), 32'h69);
    chk("slow_ovr", 32'(ovr), 32'h0);

    // Reset in the middle of data bit 3 of an all-zero byte.
    RX = 1'b0;
    tick(B);
    tick(3 * B);
    tick(B / 2);
    rst = 1'b1;
    RX = 1'b1;
    tick(2);
    chk("mid_rst_rx_data", 32'(rx_data), 32'h0);
    chk("mid_rst_rdy", 32'(rdy), 32'h0);
    chk("mid_rst_frm", 32'(frm_err), 32'h0);
    chk("mid_rst_ovr", 32'(ovr), 32'h0);
    chk("mid_rst_go", 32'(cmd_go), 32'h0);
    chk("mid_rst_stop", 32'(cmd_stop), 32'h0);
    rst = 1'b0;
    tick(B);
    chk("post_rst_idle_rdy", 32'(rdy), 32'h0);
    send(8'hC3, B, 1'b1);
    chk("c3_data", 32'(rx_data), 32'hC3);
    chk("c3_rdy", 32'(rdy), 32'h1);
    chk("c3_ovr", 32'(ovr), 32'h0);
    chk("c3_frm", 32'(frm_cnt), 32'h1);
    chk("c3_cmds", 32'(go_cnt + stp_cnt), 32'h2);
    chk("final_pulse_align", 32'(bad_pulse), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
